map_request_arbiter: RTL
========================

# map_request_arbiter

Front-end controller that shares one `map_data_structure` instance among `NUM_REQ` requesters. It arbitrates between their requests and sequences each operation as a LOOKUP probe followed by an optional INSERT/DELETE execute cycle. It then returns a per-requester response with a status code. It sits between client blocks and the map: its map-side ports connect directly to the map's `valid_in`/`op`/`key_in`/`value_in`/`ready_out`/`value_out`/`valid_out`.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `KEY_WIDTH`, 8: key width; must match the map.
- `VALUE_WIDTH`, 16: value width; must match the map.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: grant index width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_op`  in  2*NUM_REQ  flattened op per requester: 0 NOP, 1 INSERT, 2 DELETE, 3 LOOKUP.
- `req_key`  in  KEY_WIDTH*NUM_REQ  flattened keys.
- `req_value`  in  VALUE_WIDTH*NUM_REQ  flattened insert values.
- `rsp_valid`  out  NUM_REQ  one-hot response valid.
- `rsp_ready`  in  NUM_REQ  per-requester response accept.
- `rsp_value`  out  VALUE_WIDTH  shared response value; valid for a LOOKUP hit, else 0.
- `rsp_status`  out  2  00 OK, 01 NOT_FOUND, 10 FULL.
- `map_valid_in`, `map_op[1:0]`, `map_key`, `map_value`  out  drive the map.
- `map_ready_out`, `map_valid_out`, `map_value_out`  in  from the map.

## Operation
FSM states are IDLE, PROBE, EXEC and RESP.

**IDLE**
- Grant `g` = first index with `req_valid` set, searching from `last_grant+1` modulo `NUM_REQ`.
- `req_ready[g]`=1 combinationally in IDLE only.
- On handshake, latch op/key/value and `g`, update `last_grant`=`g`, then go to PROBE.
- NOP requests go directly to RESP with status OK and value 0.

**PROBE** (one cycle)
- Drive `map_valid_in`=1, `map_op`=LOOKUP and the latched key.
- Register `hit`=`map_valid_out`, `hit_value`=`map_value_out`, and `full`=~`map_ready_out`.
- Decision:
  - LOOKUP: go to RESP, with OK plus `hit_value` on a hit, or NOT_FOUND with 0 on a miss.
  - DELETE miss: go to RESP with NOT_FOUND.
  - INSERT while `full` (hit or miss): go to RESP with FULL. The map updates nothing when full.
  - Otherwise go to EXEC.

**EXEC** (one cycle)
- Drive `map_valid_in`=1, the latched op, key and value. The map commits at the end of this cycle.
- Go to RESP with OK.

**RESP**
- Hold `rsp_valid[g]`=1 with value and status stable until `rsp_ready[g]`, then go to IDLE.
- No new grant is issued before the state returns to IDLE.

**Other rules**
- Outside PROBE/EXEC: `map_valid_in`=0, `map_op`=NOP, `map_key`/`map_value`=0.
- `req_*` and `rsp_ready` bits of non-granted requesters are ignored outside their handshake.

## Timing
**Reset values**
- `req_ready`=0, `rsp_valid`=0, `rsp_value`=0, `rsp_status`=00.
- `map_valid_in`=0, `map_op`=NOP, state IDLE, `last_grant`=`NUM_REQ-1`, so requester 0 wins first.

**Latency**, with the accept at cycle T:
- PROBE at T+1.
- `rsp_valid` rises at T+2 for LOOKUP, for a DELETE miss and for a FULL insert.
- `rsp_valid` rises at T+3 when EXEC is used.
- NOP: `rsp_valid` at T+1.

**Throughput**
- One operation per 3–4 cycles plus the response wait.
- Next accept is no earlier than the cycle after the `rsp_ready` handshake.

**Boundary conditions**
- Simultaneous requests: exactly one is granted; round-robin guarantees each requester waits at most `NUM_REQ-1` grants.
- `last_grant` wrap: it wraps from `NUM_REQ-1` to 0.
- Map full: INSERT of an existing key also returns FULL, matching the map's ready gating.
- Reset mid-operation: the in-flight request is dropped with no response. The map is reset by the same reset.

## Configuration
- `MAP_ARB_FIXED_PRIO_EN` defined: grant is always the lowest-index valid requester, and `last_grant` is unused.
- Undefined (default): round-robin as described above.

## Test plan
- **Single INSERT:** reset, then requester 0 INSERT key 0x11 value 0xBEEF. Expect `rsp_valid[0]` at T+3 with OK. A following LOOKUP 0x11 returns 0xBEEF/OK at T+2.
- **Misses:** LOOKUP key 0x22 on an empty map gives NOT_FOUND with value 0 at T+2. DELETE 0x22 gives NOT_FOUND and the map is unchanged.
- **Full map:** fill all 16 entries, then INSERT a new key 0x99. Expect FULL, and a LOOKUP of 0x99 gives NOT_FOUND.
- **Round-robin:** all four requesters hold LOOKUP with `rsp_ready`=1. Grants go 0,1,2,3,0. With `MAP_ARB_FIXED_PRIO_EN`, requester 0 is granted every time.
- **Backpressure:** hold `rsp_ready[2]`=0 for 10 cycles. `rsp_valid[2]` and the data stay stable, and no other `req_ready` asserts.
- **Reset mid-operation:** assert reset during EXEC of an INSERT. Next cycle all outputs are at reset values and no response is issued.

Source files
------------

// File: rtl/map_request_arbiter.sv
// rtl/map_request_arbiter.sv - shares one map_data_structure among NUM_REQ requesters
//
// Purpose:
//   Arbitrates between NUM_REQ requesters and runs each accepted operation
//   against the map as a LOOKUP probe cycle, optionally followed by an
//   INSERT/DELETE execute cycle. It then holds a per-requester response until
//   that requester accepts it.
//
// Configuration macro:
//   MAP_ARB_FIXED_PRIO_EN  defined   : the lowest-index valid requester always wins
//                          undefined : round-robin starting after the last grant
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   req_valid/req_ready per-requester request handshake (req_ready one-hot or zero)
//   req_op/key/value    flattened per-requester op (0 NOP,1 INS,2 DEL,3 LKP), key, value
//   rsp_valid/rsp_ready per-requester response handshake (rsp_valid one-hot or zero)
//   rsp_value           shared response value (LOOKUP hit data, else 0)
//   rsp_status          00 OK, 01 NOT_FOUND, 10 FULL
//   map_valid_in/op/key/value          request to the map
//   map_ready_out/valid_out/value_out  response from the map

module map_request_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int KEY_WIDTH   = 8,
    parameter int VALUE_WIDTH = 16,
    parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [VALUE_WIDTH-1:0]         rsp_value,
    output logic [1:0]                     rsp_status,
    output logic                           map_valid_in,
    output logic [1:0]                     map_op,
    output logic [KEY_WIDTH-1:0]           map_key,
    output logic [VALUE_WIDTH-1:0]         map_value,
    input  logic                           map_ready_out,
    input  logic                           map_valid_out,
    input  logic [VALUE_WIDTH-1:0]         map_value_out
);

    localparam logic [1:0] OP_NOP    = 2'd0;
    localparam logic [1:0] OP_INSERT = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_LOOKUP = 2'd3;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_FOUND = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t                   state_q;
    logic [ID_WIDTH-1:0]      last_grant_q;
    logic [ID_WIDTH-1:0]      gnt_q;
    logic [1:0]               op_q;
    logic [KEY_WIDTH-1:0]     key_q;
    logic [VALUE_WIDTH-1:0]   value_q;

    logic [NUM_REQ-1:0]       rsp_valid_q;
    logic [VALUE_WIDTH-1:0]   rsp_value_q;
    logic [1:0]               rsp_status_q;

    logic                     map_valid_q;
    logic [1:0]               map_op_q;
    logic [KEY_WIDTH-1:0]     map_key_q;
    logic [VALUE_WIDTH-1:0]   map_value_q;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic                     grant_found;
    logic [ID_WIDTH-1:0]      grant_idx;

`ifdef MAP_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest valid index is the last to win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(i);
            end
        end
    end
`else
    logic [ID_WIDTH-1:0]      cand_idx;

    // Visit requesters in order starting just after the previous winner;
    // the first valid one found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = ID_WIDTH'((int'(last_grant_q) + 1 + i) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end
`endif

    // Fields of the requester currently being offered the grant.
    logic [1:0]               sel_op;
    logic [KEY_WIDTH-1:0]     sel_key;
    logic [VALUE_WIDTH-1:0]   sel_value;

    always_comb begin
        sel_op    = OP_NOP;
        sel_key   = '0;
        sel_value = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_WIDTH'(i)) begin
                sel_op    = req_op[2*i +: 2];
                sel_key   = req_key[KEY_WIDTH*i +: KEY_WIDTH];
                sel_value = req_value[VALUE_WIDTH*i +: VALUE_WIDTH];
            end
        end
    end

    // Accept is offered only while idle; since the grant is always a valid
    // requester, an offered grant is also a completed handshake.
    always_comb begin
        req_ready = '0;
        if (state_q == S_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    logic [NUM_REQ-1:0]       gnt_onehot;

    always_comb begin
        gnt_onehot        = '0;
        gnt_onehot[gnt_q] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            gnt_q        <= '0;
            op_q         <= OP_NOP;
            key_q        <= '0;
            value_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_value_q  <= '0;
            rsp_status_q <= ST_OK;
            map_valid_q  <= 1'b0;
            map_op_q     <= OP_NOP;
            map_key_q    <= '0;
            map_value_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        gnt_q        <= grant_idx;
                        last_grant_q <= grant_idx;
                        op_q         <= sel_op;
                        key_q        <= sel_key;
                        value_q      <= sel_value;
                        if (sel_op == OP_NOP) begin
                            // Nothing to ask the map: answer straight away.
                            state_q      <= S_RESP;
                            rsp_valid_q  <= req_ready;
                            rsp_value_q  <= '0;
                            rsp_status_q <= ST_OK;
                        end else begin
                            state_q     <= S_PROBE;
                            map_valid_q <= 1'b1;
                            map_op_q    <= OP_LOOKUP;
                            map_key_q   <= sel_key;
                            map_value_q <= '0;
                        end
                    end
                end

                S_PROBE: begin
                    // Probe result is consumed in the same cycle it is driven;
                    // the map bus returns to idle unless an execute follows.
                    map_valid_q <= 1'b0;
                    map_op_q    <= OP_NOP;
                    map_key_q   <= '0;
                    map_value_q <= '0;
                    case (op_q)
                        OP_LOOKUP: begin
                            state_q      <= S_RESP;
                            rsp_valid_q  <= gnt_onehot;
                            rsp_value_q  <= map_valid_out ? map_value_out : '0;
                            rsp_status_q <= map_valid_out ? ST_OK : ST_NOT_FOUND;
                        end
                        OP_DELETE: begin
                            if (!map_valid_out) begin
                                state_q      <= S_RESP;
                                rsp_valid_q  <= gnt_onehot;
                                rsp_value_q  <= '0;
                                rsp_status_q <= ST_NOT_FOUND;
                            end else begin
                                state_q     <= S_EXEC;
                                map_valid_q <= 1'b1;
                                map_op_q    <= OP_DELETE;
                                map_key_q   <= key_q;
                            end
                        end
                        OP_INSERT: begin
                            // A full map refuses every insert, even an update
                            // of a key it already holds.
                            if (!map_ready_out) begin
                                state_q      <= S_RESP;
                                rsp_valid_q  <= gnt_onehot;
                                rsp_value_q  <= '0;
                                rsp_status_q <= ST_FULL;
                            end else begin
                                state_q     <= S_EXEC;
                                map_valid_q <= 1'b1;
                                map_op_q    <= OP_INSERT;
                                map_key_q   <= key_q;
                                map_value_q <= value_q;
                            end
                        end
                        default: begin
                            // NOP never reaches the probe; answer OK if it did.
                            state_q      <= S_RESP;
                            rsp_valid_q  <= gnt_onehot;
                            rsp_value_q  <= '0;
                            rsp_status_q <= ST_OK;
                        end
                    endcase
                end

                S_EXEC: begin
                    state_q      <= S_RESP;
                    map_valid_q  <= 1'b0;
                    map_op_q     <= OP_NOP;
                    map_key_q    <= '0;
                    map_value_q  <= '0;
                    rsp_valid_q  <= gnt_onehot;
                    rsp_value_q  <= '0;
                    rsp_status_q <= ST_OK;
                end

                S_RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        state_q      <= S_IDLE;
                        rsp_valid_q  <= '0;
                        rsp_value_q  <= '0;
                        rsp_status_q <= ST_OK;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_value    = rsp_value_q;
    assign rsp_status   = rsp_status_q;
    assign map_valid_in = map_valid_q;
    assign map_op       = map_op_q;
    assign map_key      = map_key_q;
    assign map_value    = map_value_q;

endmodule
